// File: rtl/bp_be_mock_frontend_pkg.sv
// Shared types for the mock front end: FE command and FE queue message layouts,
// opcode / message-type / exception enums and the PC-generator FSM states.
package bp_be_mock_frontend_pkg;

   localparam int unsigned VaddrWidth             = 39;
   localparam int unsigned PaddrWidth             = 56;
   localparam int unsigned AsidWidth              = 10;
   localparam int unsigned BranchMetadataFwdWidth = 36;
   localparam int unsigned InstrWidth             = 32;

   localparam int unsigned PpnWidth          = PaddrWidth - 12;
   localparam int unsigned FeCmdOperandWidth = VaddrWidth + PpnWidth + AsidWidth;
   localparam int unsigned FeCmdPadWidth     = FeCmdOperandWidth - VaddrWidth;
   localparam int unsigned FeCmdWidth        = 3 + FeCmdOperandWidth;

   localparam int unsigned FePayloadWidth = VaddrWidth + InstrWidth + BranchMetadataFwdWidth;
   localparam int unsigned FeExcPadWidth  = FePayloadWidth - VaddrWidth - 2;
   localparam int unsigned FeQueueWidth   = 1 + FePayloadWidth;

   typedef enum logic [2:0] {
      OpStateReset    = 3'd0,
      OpPcRedirection = 3'd1,
      OpInterrupt     = 3'd2,
      OpIcacheFence   = 3'd3,
      OpAttachItlb    = 3'd4,
      OpItlbFence     = 3'd5
   } fe_cmd_opcode_e;

   typedef enum logic {
      MsgFetch     = 1'b0,
      MsgException = 1'b1
   } fe_msg_type_e;

   typedef enum logic [1:0] {
      ExcInstrMisaligned = 2'd0,
      ExcItlbMiss        = 2'd1,
      ExcIllegalInstr    = 2'd2
   } fe_exception_code_e;

   typedef enum logic [0:0] {
      StRun   = 1'b0,
      StStall = 1'b1
   } pc_gen_state_e;

   typedef struct packed {
      logic [VaddrWidth-1:0]    pc;
      logic [FeCmdPadWidth-1:0] pad;
   } fe_cmd_pc_redirect_s;

   typedef struct packed {
      logic [VaddrWidth-1:0] vaddr;
      logic [PpnWidth-1:0]   ppn;
      logic [AsidWidth-1:0]  asid;
   } fe_cmd_itlb_map_s;

   typedef union packed {
      fe_cmd_pc_redirect_s pc_redirect;
      fe_cmd_itlb_map_s    itlb_map;
   } fe_cmd_operand_u;

   typedef struct packed {
      fe_cmd_opcode_e  opcode;
      fe_cmd_operand_u operand;
   } fe_cmd_s;

   typedef struct packed {
      logic [VaddrWidth-1:0]             pc;
      logic [InstrWidth-1:0]             instr;
      logic [BranchMetadataFwdWidth-1:0] branch_metadata_fwd;
   } fe_fetch_s;

   typedef struct packed {
      logic [VaddrWidth-1:0]    vaddr;
      fe_exception_code_e       exception_code;
      logic [FeExcPadWidth-1:0] pad;
   } fe_exception_s;

   typedef union packed {
      fe_fetch_s     fetch;
      fe_exception_s exception;
   } fe_payload_u;

   typedef struct packed {
      fe_msg_type_e msg_type;
      fe_payload_u  payload;
   } fe_queue_s;

   // Only these two opcodes carry a PC the front end must adopt.
   function automatic logic is_pc_write(logic [2:0] opcode);
      return (opcode == OpStateReset) || (opcode == OpPcRedirection);
   endfunction

endpackage

// File: rtl/bp_be_mock_frontend_pc_gen.sv
// Fetch PC register, run/stall FSM and next-PC selection for the mock front end.
module bp_be_mock_frontend_pc_gen
   import bp_be_mock_frontend_pkg::*;
#(
   parameter logic [VaddrWidth-1:0] ResetPc = 39'h00_8000_0000
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  cmd_v_i,
   input  logic [2:0]            cmd_opcode_i,
   input  logic [VaddrWidth-1:0] cmd_pc_i,
   input  logic                  queue_rdy_i,
   output logic [VaddrWidth-1:0] pc_o,
   output logic                  queue_v_o,
   output logic                  cmd_yumi_o,
   output logic                  misaligned_o
);

   pc_gen_state_e         state_q, state_d;
   logic [VaddrWidth-1:0] pc_q, pc_d;

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q <= StRun;
         pc_q    <= ResetPc;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      misaligned_o = |pc_q[1:0];
      cmd_yumi_o   = cmd_v_i & reset_i;
      // A pending command blocks issue so a redirect never races a stale fetch.
      queue_v_o    = queue_rdy_i & reset_i & (state_q == StRun) & ~cmd_v_i;

      if (cmd_yumi_o) begin
         state_d = StRun;
         if (is_pc_write(cmd_opcode_i)) begin
            pc_d = cmd_pc_i;
         end
      end else if (queue_v_o) begin
         if (misaligned_o) begin
            state_d = StStall;
         end else begin
            pc_d = pc_q + VaddrWidth'(4);
         end
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/bp_be_mock_frontend.sv
// Mock instruction front end: fetches one word per cycle from a combinational boot ROM
// and turns it into FE queue messages, following PC changes commanded by the back end.
module bp_be_mock_frontend
   import bp_be_mock_frontend_pkg::*;
#(
   parameter int unsigned             BootRomEls   = 512,
   parameter int unsigned             BootRomWidth = 32,
   parameter logic [VaddrWidth-1:0]   ResetPc      = 39'h00_8000_0000,
   localparam int unsigned            RomAddrWidth = $clog2(BootRomEls)
) (
   input  logic                      clk_i,
   input  logic                      reset_i,

   input  logic [FeCmdWidth-1:0]     fe_cmd_i,
   input  logic                      fe_cmd_v_i,
   output logic                      fe_cmd_rdy_o,

   output logic [FeQueueWidth-1:0]   fe_queue_o,
   output logic                      fe_queue_v_o,
   input  logic                      fe_queue_rdy_i,

   output logic [RomAddrWidth-1:0]   boot_rom_addr_o,
   input  logic [BootRomWidth-1:0]   boot_rom_data_i
);

   fe_cmd_s               cmd;
   fe_queue_s             msg;
   logic [VaddrWidth-1:0] pc;
   logic                  misaligned;
   logic                  unused_cmd_pad;

   assign cmd            = fe_cmd_s'(fe_cmd_i);
   assign unused_cmd_pad = ^cmd.operand.pc_redirect.pad;

   bp_be_mock_frontend_pc_gen #(
      .ResetPc (ResetPc)
   ) u_pc_gen (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .cmd_v_i      (fe_cmd_v_i),
      .cmd_opcode_i (cmd.opcode),
      .cmd_pc_i     (cmd.operand.pc_redirect.pc),
      .queue_rdy_i  (fe_queue_rdy_i),
      .pc_o         (pc),
      .queue_v_o    (fe_queue_v_o),
      .cmd_yumi_o   (fe_cmd_rdy_o),
      .misaligned_o (misaligned)
   );

   // Word address; the PC silently wraps modulo the ROM size.
   assign boot_rom_addr_o = pc[2 +: RomAddrWidth];

   always_comb begin
      msg = '0;
      if (misaligned) begin
         msg.msg_type                         = MsgException;
         msg.payload.exception.vaddr          = pc;
         msg.payload.exception.exception_code = ExcInstrMisaligned;
      end else begin
         msg.msg_type                          = MsgFetch;
         msg.payload.fetch.pc                  = pc;
         msg.payload.fetch.instr               = boot_rom_data_i[InstrWidth-1:0];
         msg.payload.fetch.branch_metadata_fwd = '0;
      end
   end

   assign fe_queue_o = msg;

endmodule

// File: tb/tb_bp_be_mock_frontend.sv
// Bench for bp_be_mock_frontend: directed test-plan steps followed by random traffic,
// every cycle compared against a PC/stall reference model held in the bench.
module tb_bp_be_mock_frontend;
   import bp_be_mock_frontend_pkg::*;

   localparam int unsigned    RomEls  = 512;
   localparam logic [38:0]    ResetPc = 39'h00_8000_0000;

   logic                    clk = 1'b0;
   logic                    reset_n;
   logic [FeCmdWidth-1:0]   fe_cmd;
   logic                    fe_cmd_v;
   logic                    fe_cmd_rdy;
   logic [FeQueueWidth-1:0] fe_queue;
   logic                    fe_queue_v;
   logic                    fe_queue_rdy;
   logic [8:0]              rom_addr;
   logic [31:0]             rom_data;
   logic [31:0]             rom [RomEls];

   always #5 clk = ~clk;

   assign rom_data = rom[rom_addr];

   bp_be_mock_frontend dut (
      .clk_i           (clk),
      .reset_i         (reset_n),
      .fe_cmd_i        (fe_cmd),
      .fe_cmd_v_i      (fe_cmd_v),
      .fe_cmd_rdy_o    (fe_cmd_rdy),
      .fe_queue_o      (fe_queue),
      .fe_queue_v_o    (fe_queue_v),
      .fe_queue_rdy_i  (fe_queue_rdy),
      .boot_rom_addr_o (rom_addr),
      .boot_rom_data_i (rom_data)
   );

   int          errors = 0;
   int          checks = 0;
   logic [38:0] m_pc;
   bit          m_stall;
   bit          m_valid;
   fe_queue_s   q;

   task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [FeQueueWidth-1:0] expected_msg(logic [38:0] pc);
      fe_queue_s m;
      m = '0;
      if (pc % 4 != 0) begin
         m.msg_type                         = MsgException;
         m.payload.exception.vaddr          = pc;
         m.payload.exception.exception_code = ExcInstrMisaligned;
      end else begin
         m.msg_type            = MsgFetch;
         m.payload.fetch.pc    = pc;
         m.payload.fetch.instr = rom[(pc / 4) % RomEls];
      end
      return m;
   endfunction

   // One cycle: drive inputs, compare outputs against the model, then advance the model.
   task automatic step(bit rst_n, bit cmd_v, logic [2:0] op, logic [38:0] cpc, bit rdy);
      fe_cmd_s c;
      bit      exp_v;
      @(posedge clk);
      #1;
      c                         = '0;
      c.opcode                  = fe_cmd_opcode_e'(op);
      c.operand.pc_redirect.pc  = cpc;
      reset_n                   = rst_n;
      fe_cmd                    = c;
      fe_cmd_v                  = cmd_v;
      fe_queue_rdy              = rdy;
      #2;
      exp_v = rst_n && rdy && !cmd_v && !m_stall;
      check("queue_v", fe_queue_v, exp_v);
      check("cmd_rdy", fe_cmd_rdy, cmd_v && rst_n);
      if (m_valid) check("rom_addr", rom_addr, (m_pc / 4) % RomEls);
      if (exp_v) check("queue_msg", fe_queue, expected_msg(m_pc));
      if (!rst_n) begin
         m_pc    = ResetPc;
         m_stall = 1'b0;
         m_valid = 1'b1;
      end else if (cmd_v) begin
         if (op == 3'd0 || op == 3'd1) m_pc = cpc;
         m_stall = 1'b0;
      end else if (exp_v) begin
         if (m_pc % 4 == 0) m_pc = m_pc + 39'd4;
         else               m_stall = 1'b1;
      end
   endtask

   task automatic check_fetch(string tag, logic [38:0] pc, logic [31:0] instr);
      q = fe_queue_s'(fe_queue);
      check({tag, "_v"}, fe_queue_v, 1'b1);
      check({tag, "_type"}, q.msg_type, MsgFetch);
      check({tag, "_pc"}, q.payload.fetch.pc, pc);
      check({tag, "_instr"}, q.payload.fetch.instr, instr);
   endtask

   initial begin
      logic [38:0] rpc;
      for (int i = 0; i < RomEls; i++) rom[i] = $urandom;
      rom[0]       = 32'h0000_0013;
      rom[1]       = 32'h0010_0093;
      m_valid      = 1'b0;
      m_stall      = 1'b0;
      m_pc         = '0;
      reset_n      = 1'b0;
      fe_cmd       = '0;
      fe_cmd_v     = 1'b0;
      fe_queue_rdy = 1'b0;

      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'd0, '0, 1'b1);

      // Reset release and first two fetches
      step(1'b1, 1'b0, 3'd0, '0, 1'b1);
      check_fetch("first", 39'h00_8000_0000, 32'h0000_0013);
      step(1'b1, 1'b0, 3'd0, '0, 1'b1);
      check_fetch("second", 39'h00_8000_0004, 32'h0010_0093);

      // Queue full for three cycles, stalled PC delivered once afterwards
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 3'd0, '0, 1'b0);
      step(1'b1, 1'b0, 3'd0, '0, 1'b1);
      check_fetch("after_full", 39'h00_8000_0008, rom[2]);
      step(1'b1, 1'b0, 3'd0, '0, 1'b1);
      check_fetch("after_full_next", 39'h00_8000_000c, rom[3]);

      // Redirect
      step(1'b1, 1'b1, 3'd1, 39'h00_8000_0040, 1'b1);
      step(1'b1, 1'b0, 3'd0, '0, 1'b1);
      check_fetch("redirect", 39'h00_8000_0040, rom[16]);

      // Misaligned redirect: one exception, then silence until a command
      step(1'b1, 1'b1, 3'd1, 39'h00_8000_0042, 1'b1);
      step(1'b1, 1'b0, 3'd0, '0, 1'b1);
      q = fe_queue_s'(fe_queue);
      check("exc_type", q.msg_type, MsgException);
      check("exc_code", q.payload.exception.exception_code, ExcInstrMisaligned);
      check("exc_vaddr", q.payload.exception.vaddr, 39'h00_8000_0042);
      step(1'b1, 1'b0, 3'd0, '0, 1'b1);
      check("stall_v", fe_queue_v, 1'b0);
      step(1'b1, 1'b0, 3'd0, '0, 1'b1);
      step(1'b1, 1'b1, 3'd0, 39'h00_8000_0000, 1'b1);
      step(1'b1, 1'b0, 3'd0, '0, 1'b1);
      check_fetch("resume", 39'h00_8000_0000, 32'h0000_0013);

      // Fence at pc 0x80000010 leaves the PC alone
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 3'd0, '0, 1'b1);
      step(1'b1, 1'b1, 3'd3, 39'h00_0012_3450, 1'b1);
      step(1'b1, 1'b0, 3'd0, '0, 1'b1);
      check_fetch("fence", 39'h00_8000_0010, rom[4]);

      // Reset asserted with a command pending
      step(1'b0, 1'b1, 3'd1, 39'h00_8000_0100, 1'b1);
      step(1'b1, 1'b0, 3'd0, '0, 1'b1);
      check_fetch("post_reset", ResetPc, 32'h0000_0013);

      // Address wraps modulo the ROM depth
      step(1'b1, 1'b1, 3'd1, ResetPc + 39'(4 * RomEls), 1'b1);
      step(1'b1, 1'b0, 3'd0, '0, 1'b1);
      check("wrap_addr", rom_addr, 9'd0);
      check_fetch("wrap", ResetPc + 39'(4 * RomEls), 32'h0000_0013);

      // Random traffic
      for (int i = 0; i < 2000; i++) begin
         rpc = ResetPc + 39'(4 * $urandom_range(0, 1100));
         if ($urandom_range(0, 7) == 0) rpc = rpc + 39'($urandom_range(1, 3));
         step($urandom_range(0, 99) != 0, $urandom_range(0, 9) == 0,
              3'($urandom_range(0, 7)), rpc, $urandom_range(0, 3) != 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
